audio_sram_arbiter: RTL

//  Shares the single 256Kx16 off-chip SRAM port between the record path (word writes) and the

---
 rtl/audio_sram_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/audio_sram_arbiter.sv
// Round-robin arbiter sharing one async SRAM port between record writes and playback reads.
// Optional SRAM_ARB_STATS_EN adds saturating write/read/conflict counters.
module audio_sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned ADDR_W        = 18,
  parameter int unsigned DATA_W        = 16
) (
  input  logic              AUD_BCLK,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_conflict_cnt
`endif
);

  localparam int unsigned CNT_W = 4;
  // Legal ACCESS_CYCLES is 1..15; cnt runs 0..ACCESS_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ACT,
    WR_END,
    RD_ACT,
    RD_END
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_wr_q, last_wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_data_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_d, oe_n_d, we_n_d;
  logic              wr_ack_d, rd_valid_d, busy_d;

  // Next-state, latched-request and next-pin computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    addr_d    = SRAM_ADDR;
    data_d    = data_q;
    rd_data_d = rd_data;

    case (state_q)
      IDLE: begin
        // On a conflict the side that did not win last time is granted.
        if (wr_req && (!rd_req || !last_wr_q)) begin
          state_d   = WR_ACT;
          last_wr_d = 1'b1;
          addr_d    = wr_addr;
          data_d    = wr_data;
          cnt_d     = '0;
        end else if (rd_req) begin
          state_d   = RD_ACT;
          last_wr_d = 1'b0;
          addr_d    = rd_addr;
          cnt_d     = '0;
        end
      end
      WR_ACT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = WR_END;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_END: state_d = IDLE;
      RD_ACT: begin
        if (cnt_q == CNT_LAST) begin
          rd_data_d = SRAM_DQ;
          state_d   = RD_END;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_END:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ce_n_d     = (state_d == IDLE);
    we_n_d     = (state_d != WR_ACT);
    oe_n_d     = (state_d != RD_ACT);
    dq_oe_d    = (state_d == WR_ACT) || (state_d == WR_END);
    wr_ack_d   = (state_d == WR_END);
    rd_valid_d = (state_d == RD_END);
    busy_d     = (state_d != IDLE);
  end

  // State and registered pins; reset releases every strobe immediately.
  always_ff @(posedge AUD_BCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
      SRAM_ADDR <= '0;
      data_q    <= '0;
      rd_data   <= '0;
      dq_oe_q   <= 1'b0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      SRAM_ADDR <= addr_d;
      data_q    <= data_d;
      rd_data   <= rd_data_d;
      dq_oe_q   <= dq_oe_d;
      SRAM_CE_N <= ce_n_d;
      SRAM_OE_N <= oe_n_d;
      SRAM_WE_N <= we_n_d;
      SRAM_UB_N <= ce_n_d;
      SRAM_LB_N <= ce_n_d;
      wr_ack    <= wr_ack_d;
      rd_valid  <= rd_valid_d;
      busy      <= busy_d;
    end
  end

  // Data is driven only across WR_ACT/WR_END, so it never overlaps OE_N low.
  assign SRAM_DQ = dq_oe_q ? data_q : 'z;

`ifdef SRAM_ARB_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge AUD_BCLK or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_cnt       <= '0;
      stat_rd_cnt       <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (wr_ack && (stat_wr_cnt != 16'hFFFF)) begin
        stat_wr_cnt <= stat_wr_cnt + 16'd1;
      end
      if (rd_valid && (stat_rd_cnt != 16'hFFFF)) begin
        stat_rd_cnt <= stat_rd_cnt + 16'd1;
      end
      if ((state_q == IDLE) && wr_req && rd_req && (stat_conflict_cnt != 16'hFFFF)) begin
        stat_conflict_cnt <= stat_conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
